// File: rtl/lcv_mul_acc_pipe_if.sv
// Operation/result handshake bundle for lcv_mul_acc_pipe.
// The master side offers operations and consumes results; the slave side is the MAC.
interface lcv_mul_acc_pipe_if #(
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = 40,
   parameter int NUM_CH    = 4
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                        inp_valid;
   logic                        inp_ready;
   logic [1:0]                  inp_op;
   logic [CH_W-1:0]             inp_ch;
   logic signed [IN_WIDTH-1:0]  inp_a;
   logic signed [IN_WIDTH-1:0]  inp_b;
   logic signed [ACC_WIDTH-1:0] inp_c;
   logic                        outp_valid;
   logic                        outp_ready;
   logic [CH_W-1:0]             outp_ch;
   logic signed [ACC_WIDTH-1:0] outp_data;
   logic                        outp_ovf;

   modport master (
      output inp_valid, inp_op, inp_ch, inp_a, inp_b, inp_c, outp_ready,
      input  inp_ready, outp_valid, outp_ch, outp_data, outp_ovf
   );

   modport slave (
      input  inp_valid, inp_op, inp_ch, inp_a, inp_b, inp_c, outp_ready,
      output inp_ready, outp_valid, outp_ch, outp_data, outp_ovf
   );
endinterface

// File: rtl/lcv_mul_acc_pipe.sv
// Three-stage stallable multi-channel signed MAC: S1 operands, S2 a*b+c, S3 accumulator RMW.
// Define LCV_MUL_ACC_SAT_EN to saturate on overflow instead of wrapping.
module lcv_mul_acc_pipe #(
   parameter int IN_WIDTH  = 16,
   parameter int ACC_WIDTH = 40,
   parameter int NUM_CH    = 4
) (
   input logic               clk,
   input logic               rst,
   lcv_mul_acc_pipe_if.slave bus
);
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PROD_W = 2 * IN_WIDTH;
   localparam int PW     = ACC_WIDTH + 1;
   localparam int SW     = ACC_WIDTH + 2;

   localparam logic [1:0] OP_ACC   = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_READ  = 2'b11;

   generate
      if (ACC_WIDTH < 2 * IN_WIDTH + 1) begin : g_bad_width
         $error("lcv_mul_acc_pipe: ACC_WIDTH must be >= 2*IN_WIDTH+1");
      end
   endgenerate

   logic adv;

   logic                        s1_valid_q, s1_valid_d;
   logic [1:0]                  s1_op_q, s1_op_d;
   logic [CH_W-1:0]             s1_ch_q, s1_ch_d;
   logic signed [IN_WIDTH-1:0]  s1_a_q, s1_a_d;
   logic signed [IN_WIDTH-1:0]  s1_b_q, s1_b_d;
   logic signed [ACC_WIDTH-1:0] s1_c_q, s1_c_d;

   logic                        s2_valid_q, s2_valid_d;
   logic [1:0]                  s2_op_q, s2_op_d;
   logic [CH_W-1:0]             s2_ch_q, s2_ch_d;
   logic signed [PW-1:0]        s2_p_q, s2_p_d;

   logic signed [ACC_WIDTH-1:0] acc_q [NUM_CH];
   logic signed [ACC_WIDTH-1:0] acc_d [NUM_CH];

   logic                        outp_valid_q, outp_valid_d;
   logic [CH_W-1:0]             outp_ch_q, outp_ch_d;
   logic signed [ACC_WIDTH-1:0] outp_data_q, outp_data_d;
   logic                        outp_ovf_q, outp_ovf_d;

   logic signed [PROD_W-1:0]    prod;
   logic                        ch_ok;
   logic signed [ACC_WIDTH-1:0] cur;
   logic signed [ACC_WIDTH-1:0] res;
   logic signed [SW-1:0]        sum_full;
   logic [2:0]                  sum_top;
   logic                        ovf;

   assign adv            = !outp_valid_q || bus.outp_ready;
   assign bus.inp_ready  = adv;
   assign bus.outp_valid = outp_valid_q;
   assign bus.outp_ch    = outp_ch_q;
   assign bus.outp_data  = outp_data_q;
   assign bus.outp_ovf   = outp_ovf_q;

   always_comb begin
      prod       = s1_a_q * s1_b_q;
      s1_valid_d = s1_valid_q;
      s1_op_d    = s1_op_q;
      s1_ch_d    = s1_ch_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_c_d     = s1_c_q;
      s2_valid_d = s2_valid_q;
      s2_op_d    = s2_op_q;
      s2_ch_d    = s2_ch_q;
      s2_p_d     = s2_p_q;
      if (adv) begin
         s1_valid_d = bus.inp_valid;
         s1_op_d    = bus.inp_op;
         s1_ch_d    = bus.inp_ch;
         s1_a_d     = bus.inp_a;
         s1_b_d     = bus.inp_b;
         s1_c_d     = bus.inp_c;
         s2_valid_d = s1_valid_q;
         s2_op_d    = s1_op_q;
         s2_ch_d    = s1_ch_q;
         // One guard bit keeps a*b+c exact; only S3 decides about overflow.
         s2_p_d     = {{(PW - PROD_W){prod[PROD_W-1]}}, prod}
                    + {s1_c_q[ACC_WIDTH-1], s1_c_q};
      end
   end

   always_comb begin
      acc_d        = acc_q;
      outp_valid_d = outp_valid_q;
      outp_ch_d    = outp_ch_q;
      outp_data_d  = outp_data_q;
      outp_ovf_d   = outp_ovf_q;
      ch_ok        = 32'(s2_ch_q) < 32'(NUM_CH);
      cur          = ch_ok ? acc_q[s2_ch_q] : '0;
      case (s2_op_q)
         OP_ACC:   sum_full = {{2{cur[ACC_WIDTH-1]}}, cur} + {s2_p_q[PW-1], s2_p_q};
         OP_LOAD:  sum_full = {s2_p_q[PW-1], s2_p_q};
         OP_CLEAR: sum_full = '0;
         default:  sum_full = '0;
      endcase
      // True result fits ACC_WIDTH only if the top three bits agree.
      sum_top = sum_full[SW-1:ACC_WIDTH-1];
      ovf     = (sum_top != 3'b000) && (sum_top != 3'b111);
`ifdef LCV_MUL_ACC_SAT_EN
      if (ovf) begin
         res = sum_full[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                              : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
         res = sum_full[ACC_WIDTH-1:0];
      end
`else
      res = sum_full[ACC_WIDTH-1:0];
`endif
      if (adv) begin
         outp_valid_d = s2_valid_q;
         if (s2_valid_q) begin
            outp_ch_d   = s2_ch_q;
            outp_data_d = '0;
            outp_ovf_d  = 1'b0;
            if (ch_ok) begin
               if (s2_op_q == OP_READ) begin
                  outp_data_d = cur;
               end else begin
                  acc_d[s2_ch_q] = res;
                  outp_data_d    = res;
                  outp_ovf_d     = ovf;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q   <= 1'b0;
         s1_op_q      <= '0;
         s1_ch_q      <= '0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_c_q       <= '0;
         s2_valid_q   <= 1'b0;
         s2_op_q      <= '0;
         s2_ch_q      <= '0;
         s2_p_q       <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
         outp_valid_q <= 1'b0;
         outp_ch_q    <= '0;
         outp_data_q  <= '0;
         outp_ovf_q   <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_op_q      <= s1_op_d;
         s1_ch_q      <= s1_ch_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_c_q       <= s1_c_d;
         s2_valid_q   <= s2_valid_d;
         s2_op_q      <= s2_op_d;
         s2_ch_q      <= s2_ch_d;
         s2_p_q       <= s2_p_d;
         for (int unsigned i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
         outp_valid_q <= outp_valid_d;
         outp_ch_q    <= outp_ch_d;
         outp_data_q  <= outp_data_d;
         outp_ovf_q   <= outp_ovf_d;
      end
   end
endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Scoreboard bench for lcv_mul_acc_pipe: a behavioural accumulator model predicts each beat.
module tb_lcv_mul_acc_pipe;
   localparam int  IW = 16;
   localparam int  AW = 40;
   localparam int  NC = 4;
   localparam logic [1:0] OP_ACC = 2'b00, OP_LOAD = 2'b01, OP_CLEAR = 2'b10, OP_READ = 2'b11;
   localparam longint MAXV = 64'sh7F_FFFF_FFFF;
   localparam longint MINV = -64'sh80_0000_0000;

   typedef struct {
      int     ch;
      longint data;
      logic   ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   exp_t   sbq[$];
   longint macc[NC];
   logic signed [63:0] last_data = '0;
   logic               last_ovf  = 1'b0;
   int                 last_ch   = 0;
   logic               hold_v    = 1'b0;
   logic signed [63:0] hold_data = '0;
   int                 hold_ch   = 0;
   logic               tog_en    = 1'b0;
   logic               pat [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
   int                 pi        = 0;

   lcv_mul_acc_pipe_if #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .NUM_CH(NC)) bus ();

   lcv_mul_acc_pipe #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .NUM_CH(NC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input int ch, input longint a,
                                  input longint b, input longint c);
      exp_t   e;
      longint t;
      e.ch  = ch;
      e.ovf = 1'b0;
      t     = 0;
      case (op)
         OP_ACC:  t = macc[ch] + a * b + c;
         OP_LOAD: t = a * b + c;
         default: t = 0;
      endcase
      if (op == OP_READ) begin
         e.data = macc[ch];
      end else begin
         e.ovf = (t > MAXV) || (t < MINV);
`ifdef LCV_MUL_ACC_SAT_EN
         if (e.ovf) e.data = (t < 0) ? MINV : MAXV;
         else       e.data = t;
`else
         e.data = (t <<< (64 - AW)) >>> (64 - AW);
`endif
         macc[ch] = e.data;
      end
      return e;
   endfunction

   // Monitor: handshakes seen at the falling edge complete on the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (bus.outp_ready) chk("rdy_hi", bus.inp_ready, 1);
         else if (bus.outp_valid) chk("rdy_lo", bus.inp_ready, 0);
         if (hold_v) begin
            chk("hold_data", bus.outp_data, hold_data);
            chk("hold_ch", bus.outp_ch, hold_ch);
         end
         hold_v    = bus.outp_valid && !bus.outp_ready;
         hold_data = bus.outp_data;
         hold_ch   = int'(bus.outp_ch);
         if (bus.outp_valid && bus.outp_ready) begin
            chk("sb_avail", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
               e = sbq.pop_front();
               chk("beat_data", bus.outp_data, e.data);
               chk("beat_ch", bus.outp_ch, e.ch);
               chk("beat_ovf", bus.outp_ovf, e.ovf);
            end
            last_data = bus.outp_data;
            last_ovf  = bus.outp_ovf;
            last_ch   = int'(bus.outp_ch);
         end
         if (bus.inp_valid && bus.inp_ready) begin
            sbq.push_back(model(bus.inp_op, int'(bus.inp_ch), longint'(bus.inp_a),
                                longint'(bus.inp_b), longint'(bus.inp_c)));
         end
      end
   end

   initial begin
      bus.outp_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tog_en) begin
            bus.outp_ready = pat[pi];
            pi = (pi + 1) % 4;
         end else begin
            bus.outp_ready = 1'b1;
         end
      end
   end

   task automatic send(input logic [1:0] op, input int ch, input int a, input int b, input longint c);
      logic got;
      int   n;
      bus.inp_valid = 1'b1;
      bus.inp_op    = op;
      bus.inp_ch    = 2'(ch);
      bus.inp_a     = 16'(a);
      bus.inp_b     = 16'(b);
      bus.inp_c     = 40'(c);
      n   = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         @(negedge clk);
         got = bus.inp_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!got) chk("send_timeout", got, 1);
      bus.inp_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain", sbq.size(), 0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) macc[i] = 0;
      sbq.delete();
      hold_v = 1'b0;
   endtask

   initial begin
      longint sum;
      bus.inp_valid = 1'b0;
      bus.inp_op    = '0;
      bus.inp_ch    = '0;
      bus.inp_a     = '0;
      bus.inp_b     = '0;
      bus.inp_c     = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", bus.outp_valid, 0);
      chk("rst_data", bus.outp_data, 0);
      chk("rst_ch", bus.outp_ch, 0);
      chk("rst_ovf", bus.outp_ovf, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_inp_ready", bus.inp_ready, 1);

      send(OP_LOAD, 0, 3, 4, 0);
      send(OP_ACC, 0, -2, 5, 1);
      drain();
      chk("ch0_acc", last_data, 3);
      chk("ch0_ovf", last_ovf, 0);

      send(OP_ACC, 1, 100, 100, 0);
      send(OP_ACC, 2, -1, 1, 0);
      send(OP_ACC, 1, 100, 100, 0);
      send(OP_ACC, 2, -1, 1, 0);
      send(OP_READ, 1, 0, 0, 0);
      drain();
      chk("rd_ch1", last_data, 20000);
      chk("rd_ch1_tag", last_ch, 1);
      send(OP_READ, 2, 0, 0, 0);
      drain();
      chk("rd_ch2", last_data, -2);
      chk("rd_ch2_tag", last_ch, 2);

      send(OP_LOAD, 0, 0, 0, MAXV);
      send(OP_ACC, 0, 1, 1, 0);
      drain();
      chk("ovf_flag", last_ovf, 1);
`ifdef LCV_MUL_ACC_SAT_EN
      chk("ovf_data", last_data, MAXV);
`else
      chk("ovf_data", last_data, MINV);
`endif
      send(OP_READ, 0, 0, 0, 0);
      drain();
      chk("ovf_not_sticky", last_ovf, 0);

      send(OP_CLEAR, 2, 0, 0, 0);
      tog_en = 1'b1;
      sum = 0;
      for (int i = 0; i < 10; i++) begin
         send(OP_ACC, 2, i + 1, i - 3, 0);
         sum += longint'((i + 1) * (i - 3));
      end
      send(OP_READ, 2, 0, 0, 0);
      drain();
      tog_en = 1'b0;
      chk("stream_sum", last_data, sum);

      send(OP_ACC, 3, 7, 1, 0);
      send(OP_CLEAR, 3, 0, 0, 0);
      drain();
      chk("clr_data", last_data, 0);
      chk("clr_ovf", last_ovf, 0);
      send(OP_READ, 3, 0, 0, 0);
      drain();
      chk("clr_read", last_data, 0);

      send(OP_ACC, 0, 1, 1, 0);
      send(OP_ACC, 0, 1, 1, 0);
      send(OP_ACC, 0, 1, 1, 0);
      #1;
      chk("pre_rst_valid", bus.outp_valid, 1);
      rst = 1'b0;
      #1;
      chk("async_rst_valid", bus.outp_valid, 0);
      chk("async_rst_data", bus.outp_data, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      send(OP_READ, 0, 0, 0, 0);
      drain();
      chk("post_rst_ch0", last_data, 0);
      send(OP_READ, 1, 0, 0, 0);
      drain();
      chk("post_rst_ch1", last_data, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog sim time expired, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end
endmodule
